dac_writer: RTL and testbench

Serial master that writes 12-bit codes to an MCP4921-class SPI DAC: 16-bit command word, MSB first, SPI mode 0, followed by an LDAC strobe that latches the output.
- Transmit-side counterpart of the ADC reader; it sits on the same FPGA clock domain.
- It takes a parallel sample plus a start strobe from the processing logic and reports completion with a one-cycle `done` pulse.

---
 rtl/dac_pkg.sv | 21 ++
 rtl/dac_writer_if.sv | 42 ++++
 rtl/dac_sclk_gen.sv | 38 +++
 rtl/dac_writer.sv | 154 +++++++++++++++
 tb/tb_dac_writer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_pkg.sv
// dac_pkg: shared types and constants for the MCP4921-class DAC writer.
// Holds the FSM state enum, command-word bit positions and word length.
package dac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CSHOLD,
    LDAC
  } dac_state_e;

  // Command word length: 4 configuration bits + 12 data bits.
  localparam int unsigned cmd_total_bits = 16;

  // Configuration bit positions inside the command word.
  localparam int unsigned ab_pos   = 15;
  localparam int unsigned buf_pos  = 14;
  localparam int unsigned ga_pos   = 13;
  localparam int unsigned shdn_pos = 12;

endpackage

// File: rtl/dac_writer_if.sv
// dac_writer_if: parallel request side plus SPI/LDAC pins of the DAC writer.
//   start, datos_dac          : write request and code from processing logic
//   ready, done               : idle flag and one-cycle completion pulse
//   chip_select, sclk_dac,
//   sdi_dac, ldac_n           : pins towards the DAC
// master = dac_writer, slave = the logic/pins on the other side.
interface dac_writer_if #(
  parameter int unsigned datos_bits = 12
);

  logic                  start;
  logic [datos_bits-1:0] datos_dac;
  logic                  ready;
  logic                  done;
  logic                  chip_select;
  logic                  sclk_dac;
  logic                  sdi_dac;
  logic                  ldac_n;

  modport master (
    input  start,
    input  datos_dac,
    output ready,
    output done,
    output chip_select,
    output sclk_dac,
    output sdi_dac,
    output ldac_n
  );

  modport slave (
    output start,
    output datos_dac,
    input  ready,
    input  done,
    input  chip_select,
    input  sclk_dac,
    input  sdi_dac,
    input  ldac_n
  );

endinterface

// File: rtl/dac_sclk_gen.sv
// dac_sclk_gen: SCLK divider. Counts clk_div cycles per half period, pulses
// tick_c on the last cycle of each half period and toggles the registered
// SCLK level on that tick. Held cleared (count 0, SCLK low) while clr=1.
//   clk_dac, rst_dac : clock, synchronous active-high reset
//   clr              : hold divider in its idle state
//   tick_c           : last cycle of the current half period (combinational)
//   sclk             : serial clock level, idles low
module dac_sclk_gen #(
  parameter int unsigned clk_div = 2
) (
  input  logic clk_dac,
  input  logic rst_dac,
  input  logic clr,
  output logic tick_c,
  output logic sclk
);

  localparam int unsigned cnt_w = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam logic [cnt_w-1:0] h_last = cnt_w'(clk_div - 1);

  logic [cnt_w-1:0] cnt_q;

  assign tick_c = (cnt_q == h_last);

  // Half-period counter and SCLK level.
  always_ff @(posedge clk_dac) begin
    if (rst_dac || clr) begin
      cnt_q <= '0;
      sclk  <= 1'b0;
    end else if (tick_c) begin
      cnt_q <= '0;
      sclk  <= ~sclk;
    end else begin
      cnt_q <= cnt_q + cnt_w'(1);
    end
  end

endmodule

// File: rtl/dac_writer.sv
// dac_writer: writes one 12-bit code to an MCP4921-class DAC per start.
// Sends the 16-bit command word MSB first in SPI mode 0, holds CS_n high for
// H cycles, pulses LDAC_n low for H cycles, then pulses done.
//   clk_dac, rst_dac : clock, synchronous active-high reset
//   bus (master)     : start/datos_dac in; ready/done and DAC pins out
module dac_writer
  import dac_pkg::*;
#(
  parameter int unsigned datos_bits = 12,
  parameter int unsigned total_bits = cmd_total_bits,
  parameter int unsigned clk_div    = 2,
  parameter logic        buffered   = 1'b1,
  parameter logic        gain_1x    = 1'b1
) (
  input  logic          clk_dac,
  input  logic          rst_dac,
  dac_writer_if.master  bus
);

  localparam int unsigned cnt_w = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam int unsigned bit_w = $clog2(total_bits);
  localparam logic [cnt_w-1:0] h_last   = cnt_w'(clk_div - 1);
  localparam logic [bit_w-1:0] bit_first = bit_w'(total_bits - 1);

  dac_state_e state_q, state_d;
  logic [bit_w-1:0]      bit_q, bit_d;
  logic [total_bits-1:0] sh_q, sh_d;
  logic [cnt_w-1:0]      hold_q, hold_d;
  logic                  cs_q, cs_d;
  logic                  ldac_q, ldac_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;

  logic                  tick_c;
  logic                  sclk_q;
  logic                  gen_clr_c;
  logic [total_bits-1:0] word_c;

  // Command word assembled from the fixed config bits and the input code.
  always_comb begin
    word_c                   = '0;
    word_c[ab_pos]           = 1'b0;
    word_c[buf_pos]          = buffered;
    word_c[ga_pos]           = gain_1x;
    word_c[shdn_pos]         = 1'b1;
    word_c[datos_bits-1:0]   = bus.datos_dac;
  end

  assign gen_clr_c = (state_q != SHIFT);

  dac_sclk_gen #(
    .clk_div (clk_div)
  ) u_sclk_gen (
    .clk_dac (clk_dac),
    .rst_dac (rst_dac),
    .clr     (gen_clr_c),
    .tick_c  (tick_c),
    .sclk    (sclk_q)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    hold_d  = hold_q;
    cs_d    = cs_q;
    ldac_d  = ldac_q;
    ready_d = ready_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          sh_d    = word_c;
          bit_d   = bit_first;
          cs_d    = 1'b0;
          ready_d = 1'b0;
        end
      end

      SHIFT: begin
        // End of a high phase: advance to the next bit. The final shift
        // empties the register so SDI returns low with CS_n.
        if (tick_c && sclk_q) begin
          sh_d = {sh_q[total_bits-2:0], 1'b0};
          if (bit_q == '0) begin
            state_d = CSHOLD;
            cs_d    = 1'b1;
            hold_d  = '0;
          end else begin
            bit_d = bit_q - bit_w'(1);
          end
        end
      end

      CSHOLD: begin
        if (hold_q == h_last) begin
          state_d = LDAC;
          hold_d  = '0;
          ldac_d  = 1'b0;
        end else begin
          hold_d = hold_q + cnt_w'(1);
        end
      end

      LDAC: begin
        if (hold_q == h_last) begin
          state_d = IDLE;
          hold_d  = '0;
          ldac_d  = 1'b1;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          hold_d = hold_q + cnt_w'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_dac) begin
    if (rst_dac) begin
      state_q <= IDLE;
      bit_q   <= '0;
      sh_q    <= '0;
      hold_q  <= '0;
      cs_q    <= 1'b1;
      ldac_q  <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      hold_q  <= hold_d;
      cs_q    <= cs_d;
      ldac_q  <= ldac_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready       = ready_q;
  assign bus.done        = done_q;
  assign bus.chip_select = cs_q;
  assign bus.sclk_dac    = sclk_q;
  assign bus.sdi_dac     = sh_q[total_bits-1];
  assign bus.ldac_n      = ldac_q;

endmodule

// File: tb/tb_dac_writer.sv
// tb_dac_writer: directed bench for dac_writer. Three instances cover the
// default config (H=2), BUF=0/GA=0 (H=2) and H=1. A negedge monitor on the
// selected instance rebuilds the word from SDI at SCLK rises and records
// timing of CS_n, LDAC_n and done.
module tb_dac_writer;

  logic        clk = 1'b0;
  logic        rst_dac = 1'b1;
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          sel = 0;
  logic        mon_clr = 1'b0;

  dac_writer_if #(.datos_bits(12)) bus_a ();
  dac_writer_if #(.datos_bits(12)) bus_b ();
  dac_writer_if #(.datos_bits(12)) bus_c ();

  dac_writer #(.clk_div(2)) u_dut_a (
    .clk_dac (clk),
    .rst_dac (rst_dac),
    .bus     (bus_a)
  );

  dac_writer #(.clk_div(2), .buffered(1'b0), .gain_1x(1'b0)) u_dut_b (
    .clk_dac (clk),
    .rst_dac (rst_dac),
    .bus     (bus_b)
  );

  dac_writer #(.clk_div(1)) u_dut_c (
    .clk_dac (clk),
    .rst_dac (rst_dac),
    .bus     (bus_c)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed pins of the selected instance.
  logic o_cs, o_sclk, o_sdi, o_ldac, o_ready, o_done;
  always_comb begin
    o_cs    = bus_a.chip_select;
    o_sclk  = bus_a.sclk_dac;
    o_sdi   = bus_a.sdi_dac;
    o_ldac  = bus_a.ldac_n;
    o_ready = bus_a.ready;
    o_done  = bus_a.done;
    if (sel == 1) begin
      o_cs    = bus_b.chip_select;
      o_sclk  = bus_b.sclk_dac;
      o_sdi   = bus_b.sdi_dac;
      o_ldac  = bus_b.ldac_n;
      o_ready = bus_b.ready;
      o_done  = bus_b.done;
    end else if (sel == 2) begin
      o_cs    = bus_c.chip_select;
      o_sclk  = bus_c.sclk_dac;
      o_sdi   = bus_c.sdi_dac;
      o_ldac  = bus_c.ldac_n;
      o_ready = bus_c.ready;
      o_done  = bus_c.done;
    end
  end

  // Monitor; times are reported as the edge index the value is sampled at.
  logic [15:0] m_word = '0, m_last_word = '0;
  int unsigned m_rises = 0, m_cs_lo = 0, m_sclk_hi = 0;
  int unsigned m_done_cnt = 0, m_done_t = 0, m_ldac_cnt = 0;
  int unsigned m_hold_run = 0, m_last_hold = 0, m_cs_fall_t = 0;
  logic        p_sclk = 1'b0, p_cs = 1'b1, p_ldac = 1'b1;

  always @(negedge clk) begin
    if (mon_clr) begin
      m_word      <= '0;
      m_last_word <= '0;
      m_rises     <= 0;
      m_cs_lo     <= 0;
      m_sclk_hi   <= 0;
      m_done_cnt  <= 0;
      m_done_t    <= 0;
      m_ldac_cnt  <= 0;
      m_hold_run  <= 0;
      m_last_hold <= 0;
      m_cs_fall_t <= 0;
    end else begin
      if (!o_cs) begin
        m_cs_lo <= m_cs_lo + 1;
        if (o_sclk) m_sclk_hi <= m_sclk_hi + 1;
        if (o_sclk && !p_sclk) begin
          m_word  <= {m_word[14:0], o_sdi};
          m_rises <= m_rises + 1;
        end
        if (p_cs) begin
          m_cs_fall_t <= cyc + 1;
          m_hold_run  <= 0;
        end
      end else begin
        if (!p_cs) begin
          m_last_word <= m_word;
          m_word      <= '0;
        end
        if (o_ldac && !o_ready) m_hold_run <= m_hold_run + 1;
      end
      if (!o_ldac) begin
        m_ldac_cnt <= m_ldac_cnt + 1;
        if (p_ldac) m_last_hold <= m_hold_run;
      end
      if (o_done) begin
        m_done_cnt <= m_done_cnt + 1;
        m_done_t   <= cyc + 1;
      end
    end
    p_sclk <= o_sclk;
    p_cs   <= o_cs;
    p_ldac <= o_ldac;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int which, input logic st, input logic [11:0] d);
    case (which)
      1:       begin bus_b.start = st; bus_b.datos_dac = d; end
      2:       begin bus_c.start = st; bus_c.datos_dac = d; end
      default: begin bus_a.start = st; bus_a.datos_dac = d; end
    endcase
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
  endtask

  // One start pulse; datos_dac is scrambled right after acceptance.
  task automatic start_xfer(input int which, input logic [11:0] d, output int unsigned t0);
    int unsigned w = 0;
    while (!o_ready && w < 200) begin
      step();
      w++;
    end
    set_in(which, 1'b1, d);
    t0 = cyc + 1;
    step();
    set_in(which, 1'b0, ~d);
  endtask

  task automatic wait_done(input int unsigned target, input int unsigned bound);
    int unsigned w = 0;
    while (m_done_cnt < target && w < bound) begin
      step();
      w++;
    end
  endtask

  initial begin
    int unsigned t0;
    int unsigned w;

    set_in(0, 1'b0, 12'h000);
    set_in(1, 1'b0, 12'h000);
    set_in(2, 1'b0, 12'h000);

    // Reset values.
    rst_dac = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("rst_cs", o_cs, 1);
    check("rst_sclk", o_sclk, 0);
    check("rst_sdi", o_sdi, 0);
    check("rst_ldac", o_ldac, 1);
    check("rst_ready", o_ready, 1);
    check("rst_done", o_done, 0);
    step();
    rst_dac = 1'b0;
    step();

    // Default config, H=2, code 0xABC.
    sel = 0;
    clear_mon();
    start_xfer(0, 12'hABC, t0);
    wait_done(1, 200);
    check("abc_done_seen", m_done_cnt, 1);
    check("abc_word", m_last_word, 16'h7ABC);
    check("abc_done_t", m_done_t, t0 + 69);
    check("abc_rises", m_rises, 16);
    check("abc_cs_lo", m_cs_lo, 64);
    check("abc_sclk_hi", m_sclk_hi, 32);
    check("abc_ldac_lo", m_ldac_cnt, 2);
    check("abc_cshold", m_last_hold, 2);
    check("abc_cs_fall_t", m_cs_fall_t, t0 + 1);
    step();
    @(negedge clk);
    check("abc_done_pulse", o_done, 0);

    // BUF=0, GA=0 instance: all-zero and all-ones codes.
    sel = 1;
    clear_mon();
    start_xfer(1, 12'h000, t0);
    wait_done(1, 200);
    check("b000_word", m_last_word, 16'h1000);
    check("b000_done_t", m_done_t, t0 + 69);
    clear_mon();
    start_xfer(1, 12'hFFF, t0);
    wait_done(1, 200);
    check("bfff_word", m_last_word, 16'h1FFF);
    check("bfff_rises", m_rises, 16);

    // Start pulses during a transfer are ignored.
    sel = 0;
    clear_mon();
    start_xfer(0, 12'hABC, t0);
    w = 0;
    while (m_done_cnt < 1 && w < 200) begin
      if (cyc + 1 == t0 + 10 || cyc + 1 == t0 + 40) set_in(0, 1'b1, 12'h321);
      else set_in(0, 1'b0, 12'h321);
      step();
      w++;
    end
    set_in(0, 1'b0, 12'h321);
    repeat (20) step();
    check("ign_done_cnt", m_done_cnt, 1);
    check("ign_word", m_last_word, 16'h7ABC);
    check("ign_rises", m_rises, 16);
    check("ign_done_t", m_done_t, t0 + 69);
    check("ign_ldac_lo", m_ldac_cnt, 2);

    // Start held across done: back-to-back second write of 0x123.
    clear_mon();
    start_xfer(0, 12'hABC, t0);
    w = 0;
    while (m_done_cnt < 1 && w < 200) begin
      if (cyc + 1 >= t0 + 60) set_in(0, 1'b1, 12'h123);
      step();
      w++;
    end
    set_in(0, 1'b0, 12'hFFF);
    check("b2b_first_word", m_last_word, 16'h7ABC);
    wait_done(2, 200);
    check("b2b_done_cnt", m_done_cnt, 2);
    check("b2b_word", m_last_word, 16'h7123);
    check("b2b_cs_fall_t", m_cs_fall_t, t0 + 70);
    check("b2b_cshold", m_last_hold, 2);
    check("b2b_done_t", m_done_t, t0 + 138);

    // Reset around the 8th SCLK rise aborts without LDAC or done.
    clear_mon();
    start_xfer(0, 12'hABC, t0);
    w = 0;
    while (m_rises < 8 && w < 100) begin
      step();
      w++;
    end
    check("rstx_rise8_seen", m_rises, 8);
    rst_dac = 1'b1;
    step();
    @(negedge clk);
    check("rstx_cs", o_cs, 1);
    check("rstx_sclk", o_sclk, 0);
    check("rstx_ready", o_ready, 1);
    check("rstx_ldac", o_ldac, 1);
    check("rstx_sdi", o_sdi, 0);
    step();
    rst_dac = 1'b0;
    repeat (80) step();
    check("rstx_ldac_lo", m_ldac_cnt, 0);
    check("rstx_done_cnt", m_done_cnt, 0);

    // H=1 instance, code 0x555.
    sel = 2;
    clear_mon();
    start_xfer(2, 12'h555, t0);
    wait_done(1, 100);
    check("h1_word", m_last_word, 16'h7555);
    check("h1_done_t", m_done_t, t0 + 35);
    check("h1_rises", m_rises, 16);
    check("h1_cs_lo", m_cs_lo, 32);
    check("h1_sclk_hi", m_sclk_hi, 16);
    check("h1_ldac_lo", m_ldac_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
